// File: rtl/savomax_pkg.sv
// Shared format codes, tracker state type and timing helper for the
// savomax PAL/NTSC format tracker.
package savomax_pkg;

    localparam logic [2:0] FORMAT_UNKNOWN = 3'b000;
    localparam logic [2:0] FORMAT_NTSC    = 3'b010;
    localparam logic [2:0] FORMAT_PAL     = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    // Whole milliseconds to clock cycles, rounding the per-ms rate down.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/savomax_period_meter.sv
// VSYNC front end: synchroniser, falling-edge detector, saturating frame
// period counter and a one-shot "no VSYNC for too long" pulse.
module savomax_period_meter #(
    parameter int          CNT_W   = 24,
    parameter int unsigned MAX_CYC = 6250
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    output logic             vsync_edge,
    output logic [CNT_W-1:0] sample,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_CYC + 1);

    logic             sync_a;
    logic             sync_b;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             expired;

    // An edge in the saturation cycle wins, so that sample is simply invalid.
    assign vsync_edge = prev & ~sync_b;
    assign sample     = cnt;
    assign timeout    = (cnt == SAT) & ~vsync_edge & ~expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            prev    <= 1'b0;
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            sync_a <= vsync;
            sync_b <= sync_a;
            prev   <= sync_b;

            if (vsync_edge) begin
                cnt <= CNT_W'(1);
            end else if (cnt != SAT) begin
                cnt <= cnt + 1'b1;
            end

            // Holds the counter's saturation from re-firing until the next edge.
            if (vsync_edge) begin
                expired <= 1'b0;
            end else if (timeout) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/savomax_format_tracker.sv
// Continuous PAL/NTSC tracker: classifies every VSYNC period, locks after a
// run of agreeing frames and drops lock on repeated bad frames or timeout.
module savomax_format_tracker
    import savomax_pkg::*;
#(
    parameter int unsigned CLK_FREQ           = 250_000,
    parameter int unsigned NTSC_PAL_THRESHOLD = 18,
    parameter int unsigned MIN_PERIOD_MS      = 14,
    parameter int unsigned MAX_PERIOD_MS      = 25,
    parameter int unsigned LOCK_COUNT         = 4,
    parameter int unsigned LOSS_COUNT         = 2,
    parameter int          CNT_W              = 24
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             vsync_in,
    output logic [2:0]       format_out,
    output logic             format_valid_out,
    output logic [CNT_W-1:0] period_out,
    output logic             format_change_out,
    output logic             timeout_out
);

    localparam int unsigned THR_CYC = ms_to_cycles(CLK_FREQ, NTSC_PAL_THRESHOLD);
    localparam int unsigned MIN_CYC = ms_to_cycles(CLK_FREQ, MIN_PERIOD_MS);
    localparam int unsigned MAX_CYC = ms_to_cycles(CLK_FREQ, MAX_PERIOD_MS);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [CNT_W-1:0]   THR_C  = CNT_W'(THR_CYC);
    localparam logic [CNT_W-1:0]   MIN_C  = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0]   MAX_C  = CNT_W'(MAX_CYC);
    localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  LOSS_M = MISS_W'(LOSS_COUNT);

    if ((64'd1 << CNT_W) <= (64'(MAX_CYC) + 64'd1)) begin : g_cnt_w_check
        $error("savomax_format_tracker: CNT_W too narrow to hold MAX_CYC+1");
    end
    if (LOCK_COUNT < 1 || LOSS_COUNT < 1) begin : g_count_check
        $error("savomax_format_tracker: LOCK_COUNT and LOSS_COUNT must be >= 1");
    end

    logic             vsync_edge;
    logic [CNT_W-1:0] sample;
    logic             meter_timeout;

    savomax_period_meter #(
        .CNT_W   (CNT_W),
        .MAX_CYC (MAX_CYC)
    ) u_meter (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .vsync      (vsync_in),
        .vsync_edge (vsync_edge),
        .sample     (sample),
        .timeout    (meter_timeout)
    );

    state_t             state_q, state_d;
    logic [2:0]         cand_q, cand_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [2:0]         format_q, format_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               change_q, change_d;

    logic               sample_ok;
    logic [2:0]         sample_cls;
    logic [MATCH_W-1:0] match_next;
    logic [MISS_W-1:0]  miss_next;

    // A sample exactly on the threshold counts as NTSC.
    always_comb begin
        sample_ok  = (sample >= MIN_C) && (sample <= MAX_C);
        sample_cls = (sample > THR_C) ? FORMAT_PAL : FORMAT_NTSC;
        match_next = (sample_cls == cand_q) ? match_q + 1'b1 : MATCH_W'(1);
        miss_next  = miss_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        miss_d   = miss_q;
        format_d = format_q;
        valid_d  = valid_q;
        period_d = period_q;
        change_d = 1'b0;

        if (vsync_edge) begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cand_d  = FORMAT_UNKNOWN;
                    match_d = '0;
                end
                ACQUIRE: begin
                    if (!sample_ok) begin
                        cand_d  = FORMAT_UNKNOWN;
                        match_d = '0;
                    end else if (match_next == LOCK_M) begin
                        state_d  = LOCKED;
                        cand_d   = sample_cls;
                        match_d  = '0;
                        miss_d   = '0;
                        format_d = sample_cls;
                        valid_d  = 1'b1;
                        period_d = sample;
                        change_d = 1'b1;
                    end else begin
                        cand_d  = sample_cls;
                        match_d = match_next;
                    end
                end
                LOCKED: begin
                    if (sample_ok && sample_cls == format_q) begin
                        miss_d   = '0;
                        period_d = sample;
                    end else if (miss_next == LOSS_M) begin
                        // The losing sample seeds the next acquisition run.
                        state_d  = ACQUIRE;
                        cand_d   = sample_ok ? sample_cls : FORMAT_UNKNOWN;
                        match_d  = sample_ok ? MATCH_W'(1) : '0;
                        miss_d   = '0;
                        format_d = FORMAT_UNKNOWN;
                        valid_d  = 1'b0;
                        period_d = '0;
                        change_d = 1'b1;
                    end else begin
                        miss_d = miss_next;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (meter_timeout && state_q != IDLE) begin
            state_d  = IDLE;
            cand_d   = FORMAT_UNKNOWN;
            match_d  = '0;
            miss_d   = '0;
            format_d = FORMAT_UNKNOWN;
            valid_d  = 1'b0;
            period_d = '0;
            change_d = (format_q != FORMAT_UNKNOWN);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cand_q   <= FORMAT_UNKNOWN;
            match_q  <= '0;
            miss_q   <= '0;
            format_q <= FORMAT_UNKNOWN;
            valid_q  <= 1'b0;
            period_q <= '0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            format_q <= format_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            change_q <= change_d;
        end
    end

    // The timeout is only meaningful once a measurement is under way.
    assign timeout_out       = meter_timeout && (state_q != IDLE);
    assign format_out        = format_q;
    assign format_valid_out  = valid_q;
    assign period_out        = period_q;
    assign format_change_out = change_q;

endmodule

// File: tb/tb_savomax_format_tracker.sv
// Scoreboard bench for savomax_format_tracker: vsync falls with random spacing,
// expected events come from a frame-level model of the lock/loss rules.
`timescale 1ns/1ps
module tb_savomax_format_tracker;

    // Scaled clock keeps frames short: 20 cycles per ms.
    localparam int unsigned CLK_FREQ = 20_000;
    localparam int CPMS    = CLK_FREQ / 1000;
    localparam int THR     = CPMS * 18;
    localparam int MIN_P   = CPMS * 14;
    localparam int MAX_P   = CPMS * 25;
    localparam int SAT     = MAX_P + 1;
    localparam int LOCK_N  = 4;
    localparam int LOSS_N  = 2;
    localparam int PAL     = 4;
    localparam int NTSC    = 2;
    // vsync driven at a negedge: two sync flops, then the registered outputs.
    localparam int OUT_LAT = 3;
    localparam int TMO_LAT = SAT + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic [2:0]  fmt_o;
    logic        fvalid_o;
    logic [23:0] period_o;
    logic        change_o;
    logic        tmo_o;

    savomax_format_tracker #(
        .CLK_FREQ           (CLK_FREQ),
        .NTSC_PAL_THRESHOLD (18),
        .MIN_PERIOD_MS      (14),
        .MAX_PERIOD_MS      (25),
        .LOCK_COUNT         (LOCK_N),
        .LOSS_COUNT         (LOSS_N),
        .CNT_W              (24)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .vsync_in          (vsync),
        .format_out        (fmt_o),
        .format_valid_out  (fvalid_o),
        .period_out        (period_o),
        .format_change_out (change_o),
        .timeout_out       (tmo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_tmo;
        int at;
        int fmt;
        bit vld;
        int per;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model state, one update per VSYNC fall.
    bit m_active, m_locked;
    int m_cand, m_run, m_bad, m_fmt, m_per, m_prev;
    int last_fall;

    task automatic compare(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic modelReset();
        m_active = 0; m_locked = 0; m_cand = 0; m_run = 0;
        m_bad = 0; m_fmt = 0; m_per = 0; m_prev = 0;
    endtask

    task automatic modelTimeout();
        exp_q.push_back('{is_tmo: 1'b1, at: m_prev + TMO_LAT, fmt: 0, vld: 1'b0, per: 0});
        if (m_fmt != 0)
            exp_q.push_back('{is_tmo: 1'b0, at: m_prev + TMO_LAT + 1, fmt: 0, vld: 1'b0, per: 0});
        m_active = 0; m_locked = 0; m_fmt = 0; m_per = 0;
    endtask

    task automatic modelFall(input int now);
        int  s;
        bit  ok;
        int  cls;
        if (!m_active) begin
            m_active = 1; m_cand = 0; m_run = 0; m_bad = 0;
        end else begin
            s   = now - m_prev;
            ok  = (s >= MIN_P) && (s <= MAX_P);
            cls = (s > THR) ? PAL : NTSC;
            if (!m_locked) begin
                if (!ok) begin
                    m_cand = 0; m_run = 0;
                end else begin
                    if (cls == m_cand) m_run++;
                    else begin m_cand = cls; m_run = 1; end
                    if (m_run == LOCK_N) begin
                        m_locked = 1; m_fmt = cls; m_per = s; m_bad = 0;
                        exp_q.push_back('{is_tmo: 1'b0, at: now + OUT_LAT, fmt: cls, vld: 1'b1, per: s});
                    end
                end
            end else if (ok && cls == m_fmt) begin
                m_bad = 0; m_per = s;
            end else begin
                m_bad++;
                if (m_bad == LOSS_N) begin
                    m_locked = 0; m_fmt = 0; m_per = 0; m_bad = 0;
                    m_cand = ok ? cls : 0;
                    m_run  = ok ? 1 : 0;
                    exp_q.push_back('{is_tmo: 1'b0, at: now + OUT_LAT, fmt: 0, vld: 1'b0, per: 0});
                end
            end
        end
        m_prev = now;
    endtask

    task automatic tick();
        @(negedge clk);
        if (!vsync && cyc >= last_fall + 4) vsync = 1'b1;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".format"}, int'(fmt_o), m_fmt);
        compare({tag, ".valid"},  int'(fvalid_o), int'(m_locked));
        compare({tag, ".period"}, int'(period_o), m_per);
    endtask

    // Timeout-length gaps are kept well past SAT so the pre-edge status check
    // already sees the cleared outputs.
    task automatic applyStimulus(input int gap);
        int target;
        target = last_fall + gap;
        if (m_active && (target - m_prev) > SAT) modelTimeout();
        while (cyc < target) tick();
        checkOutput("pre_edge");
        vsync = 1'b0;
        modelFall(cyc);
        last_fall = cyc;
    endtask

    task automatic holdHigh(input int cycles);
        int target;
        target = cyc + cycles;
        if (m_active && (target - m_prev) > SAT) modelTimeout();
        while (cyc < target) tick();
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #1;
        compare("rst.format", int'(fmt_o), 0);
        compare("rst.valid",  int'(fvalid_o), 0);
        compare("rst.period", int'(period_o), 0);
        compare("rst.change", int'(change_o), 0);
        compare("rst.timeout", int'(tmo_o), 0);
        modelReset();
        repeat (3) tick();
        rst_n = 1'b1;
        last_fall = cyc;
    endtask

    task automatic checkEvent(input bit is_tmo);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL spurious_%s: got pulse at cycle %0d, expected none",
                     is_tmo ? "timeout" : "change", cyc);
        end else begin
            e = exp_q.pop_front();
            compare("event.kind", int'(is_tmo), int'(e.is_tmo));
            compare("event.cycle", cyc, e.at);
            if (!is_tmo) begin
                compare("event.format", int'(fmt_o), e.fmt);
                compare("event.valid",  int'(fvalid_o), int'(e.vld));
                compare("event.period", int'(period_o), e.per);
            end
        end
    endtask

    always @(negedge clk) begin
        if (tmo_o)    checkEvent(1'b1);
        if (change_o) checkEvent(1'b0);
    end

    initial begin
        int g, kind, len;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset");
        compare("reset.change", int'(change_o), 0);
        compare("reset.timeout", int'(tmo_o), 0);
        rst_n = 1'b1;
        last_fall = cyc;

        $display("[TB] PAL lock, glitch, loss and NTSC relock");
        for (int i = 0; i < 6; i++) applyStimulus(400);
        applyStimulus(150);
        for (int i = 0; i < 3; i++) applyStimulus(400);
        for (int i = 0; i < 6; i++) applyStimulus(334);

        $display("[TB] threshold and window boundaries");
        for (int i = 0; i < 5; i++) applyStimulus(THR);
        for (int i = 0; i < 6; i++) applyStimulus(THR + 1);
        applyStimulus(MIN_P);
        applyStimulus(MAX_P);
        applyStimulus(MIN_P - 1);
        applyStimulus(SAT);
        for (int i = 0; i < 5; i++) applyStimulus(MAX_P);

        $display("[TB] timeout while locked");
        holdHigh(SAT + 200);
        checkOutput("after_timeout");

        $display("[TB] randomized runs");
        for (int r = 0; r < 14; r++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                if (kind <= 3)      g = $urandom_range(THR + 1, MAX_P);
                else if (kind <= 7) g = $urandom_range(MIN_P, THR);
                else if (kind == 8) g = $urandom_range(100, MIN_P - 1);
                else                g = ($urandom_range(0, 1) == 0) ? SAT : $urandom_range(SAT + 10, SAT + 200);
                applyStimulus(g);
            end
        end

        $display("[TB] reset during acquisition");
        holdHigh(SAT + 100);
        for (int i = 0; i < 3; i++) applyStimulus(400);
        holdHigh(100);
        resetPulse();
        for (int i = 0; i < 5; i++) applyStimulus(400);
        holdHigh(OUT_LAT + 2);
        checkOutput("relock_after_reset");

        holdHigh(SAT + 100);
        checkOutput("final");
        holdHigh(SAT + 50);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("[TB] FAIL missing_event: got nothing, expected %s at cycle %0d",
                     e.is_tmo ? "timeout" : "change", e.at);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
